// File: rtl/flash_bridge_pkg.sv
// Shared types and constants for the CPU ROM to QPI flash bridge.
package flash_bridge_pkg;

    localparam int BANK_W   = 4;
    localparam int OFFSET_W = 14;
    localparam int ADDR_W   = 24;

    localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 24'h100000;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ISSUE_DMD,
        ISSUE_PF,
        WAIT_BUSY,
        WAIT_DATA
    } state_t;

    // ROM bank/offset to flash byte address; the sum wraps modulo 2^24.
    function automatic logic [ADDR_W-1:0] rom_to_flash(
        input logic [ADDR_W-1:0]   base,
        input logic [BANK_W-1:0]   bank,
        input logic [OFFSET_W-1:0] offset
    );
        return base + {{(ADDR_W-BANK_W-OFFSET_W){1'b0}}, bank, offset};
    endfunction

endpackage

// File: rtl/flash_prefetch_buf.sv
// One-byte prefetch buffer: tag (bank/offset), data, valid and hit compare.
// Latency: hit is combinational on the lookup tag; load/clear take effect next cycle.
// Backpressure: none; the owner decides when to load or clear.
module flash_prefetch_buf
    import flash_bridge_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr,
    input  logic                load,
    input  logic [BANK_W-1:0]   load_bank,
    input  logic [OFFSET_W-1:0] load_offset,
    input  logic [7:0]          load_data,
    input  logic [BANK_W-1:0]   lookup_bank,
    input  logic [OFFSET_W-1:0] lookup_offset,
    output logic                hit,
    output logic [7:0]          data
);

    logic                pf_valid;
    logic [BANK_W-1:0]   pf_bank;
    logic [OFFSET_W-1:0] pf_offset;
    logic [7:0]          pf_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pf_valid  <= 1'b0;
            pf_bank   <= '0;
            pf_offset <= '0;
            pf_data   <= '0;
        end else if (clr) begin
            pf_valid <= 1'b0;
        end else if (load) begin
            pf_valid  <= 1'b1;
            pf_bank   <= load_bank;
            pf_offset <= load_offset;
            pf_data   <= load_data;
        end
    end

    assign hit  = pf_valid && (pf_bank == lookup_bank) && (pf_offset == lookup_offset);
    assign data = pf_data;

endmodule

// File: rtl/flash_rom_bridge.sv
// CPU ROM byte reads -> qpi_flash byte reads, with a one-byte sequential prefetch.
// Latency: prefetch hit returns 1 cycle after accept; a miss strobes flash 1 cycle after accept.
// Backpressure: req_ready is high only in IDLE; an in-flight prefetch always runs to completion.
module flash_rom_bridge
    import flash_bridge_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter logic        PREFETCH  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_bank,
    input  logic [13:0] req_offset,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic        pf_hit,
    input  logic        flash_ready,
    output logic        flash_read,
    output logic [23:0] flash_addr,
    input  logic [7:0]  flash_data
);

    state_t state, next_state;

    // Bank/offset of the outstanding flash transaction and whether it is a prefetch.
    logic [BANK_W-1:0]   cur_bank;
    logic [OFFSET_W-1:0] cur_offset;
    logic                cur_is_pf;

    logic                accept;
    logic                dmd_done;
    logic                pf_load;
    logic                buf_hit;
    logic [7:0]          buf_data;
    logic [OFFSET_W-1:0] req_offset_nxt;
    logic [OFFSET_W-1:0] cur_offset_nxt;

    assign req_offset_nxt = req_offset + OFFSET_W'(1);
    assign cur_offset_nxt = cur_offset + OFFSET_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        flash_read = 1'b0;
        accept     = 1'b0;
        dmd_done   = 1'b0;
        pf_load    = 1'b0;
        case (state)
            INIT: begin
                if (flash_ready) next_state = IDLE;
            end
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = buf_hit ? ISSUE_PF : ISSUE_DMD;
                end
            end
            ISSUE_DMD, ISSUE_PF: begin
                flash_read = 1'b1;
                next_state = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!flash_ready) next_state = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (flash_ready) begin
                    if (cur_is_pf) begin
                        pf_load    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        dmd_done   = 1'b1;
                        next_state = (PREFETCH == 1'b1) ? ISSUE_PF : IDLE;
                    end
                end
            end
            default: next_state = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            pf_hit     <= 1'b0;
            flash_addr <= '0;
            cur_bank   <= '0;
            cur_offset <= '0;
            cur_is_pf  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            pf_hit     <= 1'b0;
            if (accept) begin
                cur_bank <= req_bank;
                if (buf_hit) begin
                    resp_valid <= 1'b1;
                    resp_data  <= buf_data;
                    pf_hit     <= 1'b1;
                    cur_offset <= req_offset_nxt;
                    cur_is_pf  <= 1'b1;
                    flash_addr <= rom_to_flash(BASE_ADDR, req_bank, req_offset_nxt);
                end else begin
                    cur_offset <= req_offset;
                    cur_is_pf  <= 1'b0;
                    flash_addr <= rom_to_flash(BASE_ADDR, req_bank, req_offset);
                end
            end else if (dmd_done) begin
                resp_valid <= 1'b1;
                resp_data  <= flash_data;
                if (PREFETCH == 1'b1) begin
                    cur_offset <= cur_offset_nxt;
                    cur_is_pf  <= 1'b1;
                    flash_addr <= rom_to_flash(BASE_ADDR, cur_bank, cur_offset_nxt);
                end
            end
        end
    end

    // Every accept empties the buffer: a hit consumes it, a miss makes it stale.
    flash_prefetch_buf u_pf_buf (
        .clk           (clk),
        .reset_n       (reset_n),
        .clr           (accept),
        .load          (pf_load),
        .load_bank     (cur_bank),
        .load_offset   (cur_offset),
        .load_data     (flash_data),
        .lookup_bank   (req_bank),
        .lookup_offset (req_offset),
        .hit           (buf_hit),
        .data          (buf_data)
    );

endmodule
